// File: rtl/score_read_sequencer.sv
// score_read_sequencer: fetches the diagonal, up and left neighbours of
// score-matrix cell (i,j) from a one-cycle-latency RAM, strobes them into
// the output manager buffer, then holds them valid until the consumer acks.
// Optional feature: define SCORE_READ_RANGE_CHECK_EN to reject requests
// whose indices fall outside 1..N (err pulse, no RAM reads).
module score_read_sequencer #(
    parameter int N  = 8,
    parameter int IW = 4,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [IW-1:0] i,
    input  logic [IW-1:0] j,
    input  logic          ack,
    output logic [AW-1:0] addr,
    output logic          ram_re,
    output logic          en_read,
    output logic [1:0]    count,
    output logic          signal,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_D  = 3'd1,
        RD_U  = 3'd2,
        RD_L  = 3'd3,
        FLUSH = 3'd4,
        HOLD  = 3'd5
    } state_t;

    localparam logic [AW-1:0] ROW_LEN = AW'(N + 1);
    localparam logic [AW-1:0] ONE     = AW'(1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] i_q;
    logic [IW-1:0] j_q;
    logic          done_q;
    logic          start_ok;
    logic [AW-1:0] row_cur;
    logic [AW-1:0] col_cur;

    // Latched indices widened to address width so all arithmetic wraps at AW bits
    assign row_cur = AW'(i_q);
    assign col_cur = AW'(j_q);

`ifdef SCORE_READ_RANGE_CHECK_EN
    localparam logic [IW-1:0] N_IDX = IW'(N);
    logic bad_idx;
    logic err_q;

    // A request is only usable when both indices lie in 1..N
    always_comb begin
        bad_idx  = (i == '0) || (j == '0) || (i > N_IDX) || (j > N_IDX);
        start_ok = start && !bad_idx;
    end

    // Rejected requests in IDLE produce a single-cycle error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= (state == IDLE) && start && bad_idx;
    end

    assign err = err_q;
`else
    // Without the range check every start seen in IDLE is taken
    always_comb begin
        start_ok = start;
    end

    assign err = 1'b0;
`endif

    // State register, captured indices and the completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            i_q    <= '0;
            j_q    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == HOLD) && ack;
            if ((state == IDLE) && start_ok) begin
                i_q <= i;
                j_q <= j;
            end
        end
    end

    // Next-state logic and outputs decoded from the registered state
    always_comb begin
        state_nxt = state;
        addr      = '0;
        ram_re    = 1'b0;
        en_read   = 1'b0;
        count     = 2'd0;
        signal    = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start_ok) state_nxt = RD_D;
            end
            RD_D: begin
                ram_re    = 1'b1;
                addr      = (row_cur - ONE) * ROW_LEN + (col_cur - ONE);
                state_nxt = RD_U;
            end
            RD_U: begin
                ram_re    = 1'b1;
                addr      = (row_cur - ONE) * ROW_LEN + col_cur;
                en_read   = 1'b1;
                count     = 2'd0;
                state_nxt = RD_L;
            end
            RD_L: begin
                ram_re    = 1'b1;
                addr      = row_cur * ROW_LEN + (col_cur - ONE);
                en_read   = 1'b1;
                count     = 2'd1;
                state_nxt = FLUSH;
            end
            FLUSH: begin
                en_read   = 1'b1;
                count     = 2'd2;
                state_nxt = HOLD;
            end
            HOLD: begin
                signal = 1'b1;
                if (ack) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_score_read_sequencer.sv
// tb_score_read_sequencer: directed vectors with literal expectations plus a
// cycle-based behavioural model compared against the DUT on every negedge.
module tb_score_read_sequencer;

    localparam int N    = 8;
    localparam int IW   = 4;
    localparam int AW   = 7;
    localparam int ROW  = N + 1;
    localparam int AMOD = 1 << AW;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          ack   = 1'b0;
    logic [IW-1:0] i     = '0;
    logic [IW-1:0] j     = '0;
    logic [AW-1:0] addr;
    logic          ram_re;
    logic          en_read;
    logic [1:0]    count;
    logic          signal;
    logic          busy;
    logic          done;
    logic          err;

    int n_vec  = 0;
    int n_miss = 0;
    bit cmp_on = 1'b0;

    score_read_sequencer #(.N(N), .IW(IW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .i(i), .j(j), .ack(ack),
        .addr(addr), .ram_re(ram_re), .en_read(en_read), .count(count),
        .signal(signal), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Model: m_t counts cycles since a request was accepted (0 = no request,
    // 1..4 = fetch/strobe cycles, 5 = neighbours held until ack)
    int m_t    = 0;
    int m_i    = 0;
    int m_j    = 0;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;

    function automatic bit idx_bad(input int ii, input int jj);
`ifdef SCORE_READ_RANGE_CHECK_EN
        return (ii == 0) || (jj == 0) || (ii > N) || (jj > N);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int wrap(input int v);
        return ((v % AMOD) + AMOD) % AMOD;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_i = 0; m_j = 0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = (m_t == 5) && ack;
            m_err  = 1'b0;
            if (m_t == 0) begin
                if (start) begin
                    if (idx_bad(int'(i), int'(j))) m_err = 1'b1;
                    else begin m_t = 1; m_i = int'(i); m_j = int'(j); end
                end
            end else if (m_t < 5) begin
                m_t = m_t + 1;
            end else if (ack) begin
                m_t = 0;
            end
        end
    end

    function automatic logic [14:0] model_out(input int t, input int ri, input int cj,
                                              input bit d, input bit e);
        int a;
        int c;
        a = 0;
        c = 0;
        if (t == 1) a = wrap((ri - 1) * ROW + (cj - 1));
        if (t == 2) a = wrap((ri - 1) * ROW + cj);
        if (t == 3) a = wrap(ri * ROW + (cj - 1));
        if (t >= 2 && t <= 4) c = t - 2;
        return {AW'(a), (t >= 1 && t <= 3), (t >= 2 && t <= 4), 2'(c),
                (t == 5), (t != 0), d, e};
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            logic [14:0] act;
            logic [14:0] exp;
            act = {addr, ram_re, en_read, count, signal, busy, done, err};
            exp = model_out(m_t, m_i, m_j, m_done, m_err);
            n_vec++;
            if (act !== exp) begin
                n_miss++;
                $display("[TB] FAIL cycle_model t=%0t got=%h want=%h", $time, act, exp);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_miss++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit s, input int ii, input int jj, input bit a);
        start = s;
        i     = IW'(ii);
        j     = IW'(jj);
        ack   = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cmp_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_addr", int'(addr), 0);
        rst = 1'b0;
        #1;
        checkOutput("post_release_busy", int'(busy), 0);

        // i=1,j=1 with ack high: start accepted on the first edge after release
        applyStimulus(1, 1, 1, 1);
        checkOutput("t1_c1_addr", int'(addr), 0);
        checkOutput("t1_c1_re", int'(ram_re), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t1_c2_addr", int'(addr), 1);
        checkOutput("t1_c2_en_cnt", int'(en_read) * 4 + int'(count), 4);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t1_c3_addr", int'(addr), 9);
        checkOutput("t1_c3_en_cnt", int'(en_read) * 4 + int'(count), 5);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t1_c4_en_cnt", int'(en_read) * 4 + int'(count), 6);
        checkOutput("t1_c4_re", int'(ram_re), 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t1_c5_signal", int'(signal), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t1_c6_done", int'(done), 1);
        checkOutput("t1_c6_busy", int'(busy), 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t1_c7_done", int'(done), 0);

        // Bottom-right corner cell
        applyStimulus(1, 8, 8, 1);
        checkOutput("t2_c1_addr", int'(addr), 70);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t2_c2_addr", int'(addr), 71);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t2_c3_addr", int'(addr), 79);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t2_c5_busy", int'(busy), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t2_c6_busy", int'(busy), 0);

        // Ack held low for 10 hold cycles, start pulses during hold ignored
        applyStimulus(1, 2, 2, 0);
        repeat (4) applyStimulus(0, 0, 0, 0);
        checkOutput("t3_hold_sig_0", int'(signal), 1);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(k[0], 3, 4, 0);
            checkOutput($sformatf("t3_hold_sig_%0d", k), int'(signal), 1);
        end
        applyStimulus(1, 5, 5, 1);
        checkOutput("t3_release_sig", int'(signal), 0);
        checkOutput("t3_release_done", int'(done), 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t3_start_dropped", int'(busy) + int'(ram_re), 0);

        // Reset asserted while in RD_L, then a fresh request
        applyStimulus(1, 1, 2, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t4_rdl_addr", int'(addr), 10);
        rst = 1'b1;
        #1;
        checkOutput("t4_async_addr", int'(addr), 0);
        checkOutput("t4_async_busy", int'(busy) + int'(ram_re) + int'(en_read), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t4_no_done", int'(done), 0);
        applyStimulus(1, 2, 3, 1);
        checkOutput("t4_c1_addr", int'(addr), 11);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t4_c2_addr", int'(addr), 12);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t4_c3_addr", int'(addr), 20);
        repeat (4) applyStimulus(0, 0, 0, 1);

        // Out-of-range indices
`ifdef SCORE_READ_RANGE_CHECK_EN
        applyStimulus(1, 0, 5, 1);
        checkOutput("t5a_err", int'(err), 1);
        checkOutput("t5a_busy_re", int'(busy) + int'(ram_re), 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t5a_err_clear", int'(err), 0);
        applyStimulus(1, 9, 1, 1);
        checkOutput("t5b_err", int'(err), 1);
        checkOutput("t5b_busy_re", int'(busy) + int'(ram_re), 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t5b_err_clear", int'(err), 0);
`else
        applyStimulus(1, 0, 5, 1);
        checkOutput("t5a_c1_addr", int'(addr), 123);
        checkOutput("t5a_err", int'(err), 0);
        repeat (5) applyStimulus(0, 0, 0, 1);
        checkOutput("t5a_done", int'(done), 1);
        applyStimulus(1, 9, 1, 1);
        checkOutput("t5b_c1_addr", int'(addr), 72);
        repeat (6) applyStimulus(0, 0, 0, 1);
`endif

        // Back-to-back requests with start and ack tied high
        for (int k = 1; k <= 13; k++) begin
            applyStimulus(1, 3, 3, 1);
            if (k == 7) checkOutput("t6_second_c1_addr", int'(addr), 20);
        end
        repeat (8) applyStimulus(0, 0, 0, 1);

        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/score_read_sequencer.md
SCORE_READ_SEQUENCER -- requirements
Module: score_read_sequencer

Interface
REQ-001 Parameter N, 8, sequence length; score matrix is (N+1)x(N+1), row-major, addr = row*(N+1)+col.
REQ-002 Parameter IW, 4, width of cell index inputs.
REQ-003 Parameter AW, 7, score RAM address width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  request to fetch neighbours of cell (i,j); sampled only in IDLE.
REQ-007 i, j  in  IW  target cell row/column; captured when start is accepted.
REQ-008 ack  in  1  consumer has taken diag/up/left; ends HOLD.
REQ-009 addr  out  AW  score RAM read address.
REQ-010 ram_re  out  1  score RAM read enable; RAM returns data one cycle later.
REQ-011 en_read  out  1  write strobe for the output manager buffer.
REQ-012 count  out  2  buffer slot: 0 = diag, 1 = up, 2 = left.
REQ-013 signal  out  1  buffered neighbours valid; output manager presents them while high.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse on completion.
REQ-016 err  out  1  one-cycle pulse on rejected request.

Function
REQ-017 States: IDLE, RD_D, RD_U, RD_L, FLUSH, HOLD; addr, ram_re, en_read, count, signal, busy are decoded from registered state only.
REQ-018 IDLE + start: latch i,j; go to RD_D. Start outside IDLE is ignored, with no effect on the transaction in flight.
REQ-019 RD_D: ram_re=1, addr=(i-1)*(N+1)+(j-1); next RD_U.
REQ-020 RD_U: ram_re=1, addr=(i-1)*(N+1)+j, en_read=1, count=0; next RD_L.
REQ-021 RD_L: ram_re=1, addr=i*(N+1)+(j-1), en_read=1, count=1; next FLUSH.
REQ-022 FLUSH: ram_re=0, en_read=1, count=2; next HOLD.
REQ-023 HOLD: signal=1, en_read=0; remain until ack=1, then IDLE with done=1 in the first IDLE cycle.
REQ-024 Latency: start accepted at edge 0; signal first high in cycle 5; minimum start-to-start interval 6 cycles when ack is tied high.
REQ-025 Outside RD_U/RD_L/FLUSH, en_read=0 and count=0. Outside RD_D/RD_U/RD_L, addr=0 and ram_re=0.
REQ-026 Address arithmetic is unsigned, computed at AW bits; N, IW and AW are chosen so (N+1)^2-1 fits AW bits.
REQ-027 ack outside HOLD is ignored. ack and start arriving together in HOLD: ack is honoured and start is dropped.

Reset
REQ-028 rst=1 forces IDLE immediately, including mid-transaction, with no completion.
REQ-029 While rst=1 and in the cycle after release, all outputs are 0 (addr=0, count=0, signal=0, busy=0, done=0, err=0).
REQ-030 Latched i,j reset to 0. After release the block accepts start on the first clock edge.

Configuration
REQ-031 Macro SCORE_READ_RANGE_CHECK_EN, defined:
- start in IDLE with i==0, j==0, i>N or j>N is rejected.
- Rejection gives err=1 for one cycle and the block stays IDLE with no RAM reads.
REQ-032 Macro SCORE_READ_RANGE_CHECK_EN, undefined:
- No index check; every start in IDLE is accepted.
- err is tied 0.
- Out-of-range addresses are the caller's responsibility.

Verification
REQ-033 N=8, start with i=1, j=1, ack=1:
- addr sequence 0, 1, 9 in cycles 1-3.
- en_read with count 0, 1, 2 in cycles 2-4.
- signal=1 in cycle 5; done=1 in cycle 6.
REQ-034 N=8, i=8, j=8: addr sequence 70, 71, 79; busy high in cycles 1-5.
REQ-035 ack held low for 10 cycles after HOLD entry:
- signal stays high for all 10 cycles, then falls one cycle after ack.
- start pulses issued during HOLD produce no new reads.
REQ-036 rst asserted in RD_L:
- outputs go to 0 asynchronously; no done pulse.
- a new start (i=2, j=3) then gives addr 11, 12, 20.
REQ-037 With SCORE_READ_RANGE_CHECK_EN, start with i=0, j=5 or with i=9, j=1: err=1 for one cycle, ram_re stays 0, busy stays 0.
REQ-038 Without SCORE_READ_RANGE_CHECK_EN, start with i=0, j=5: no err, and the transaction runs to done.
